// File: rtl/pwm_capture_pkg.sv
// pwm_capture_pkg
//   Shared types and helpers for the PWM capture block.
//   pcap_state_e : capture FSM states
//   cnt_max()    : all-ones terminal count for a counter of width w (w <= 32)
package pwm_capture_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } pcap_state_e;

  function automatic logic [31:0] cnt_max(input int unsigned w);
    if (w >= 32) return 32'hFFFF_FFFF;
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/pwm_capture_if.sv
// pwm_capture_if
//   Signal bundle between the PWM capture block and its user.
//   en_i      : capture enable (low = abort and idle)
//   pwm_i     : asynchronous PWM input
//   period_o  : last measured period, clk cycles
//   high_o    : last measured high time, clk cycles
//   valid_o   : one-cycle strobe, period_o/high_o just updated
//   timeout_o : one-cycle strobe, no edge for 2^CNT_W-1 cycles
//   level_o   : synchronized pwm_i level
//   master = user side, slave = capture block.
interface pwm_capture_if #(
  parameter int CNT_W = 16
);
  logic             en_i;
  logic             pwm_i;
  logic [CNT_W-1:0] period_o;
  logic [CNT_W-1:0] high_o;
  logic             valid_o;
  logic             timeout_o;
  logic             level_o;

  modport master (
    output en_i, pwm_i,
    input  period_o, high_o, valid_o, timeout_o, level_o
  );

  modport slave (
    input  en_i, pwm_i,
    output period_o, high_o, valid_o, timeout_o, level_o
  );
endinterface

// File: rtl/sync_edge_det.sv
// sync_edge_det
//   Multi-flop synchronizer for an asynchronous input plus a previous-level
//   register for edge detection. Also used for button inputs.
//   clk    : system clock
//   rst    : asynchronous reset, active-high
//   i_d    : asynchronous input
//   o_lvl  : synchronized level
//   o_rise : one-cycle pulse on a synchronized 0->1 transition
//   o_fall : one-cycle pulse on a synchronized 1->0 transition
module sync_edge_det #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_lvl,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_prev <= r_sync[STAGES-1];
    end
  end

  // Both edges take the same path, so measured widths are not skewed.
  assign o_lvl  = r_sync[STAGES-1];
  assign o_rise = r_sync[STAGES-1] & ~r_prev;
  assign o_fall = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture
//   Measures period (rise to rise) and high time of an external PWM input in
//   clk cycles. One valid strobe per complete period; a missing edge for
//   2^CNT_W-1 cycles gives a timeout strobe and returns to IDLE.
//   clk : system clock
//   rst : asynchronous reset, active-high
//   bus : pwm_capture_if slave (en_i, pwm_i in; results, strobes, level out)
//
//   state | meaning
//   IDLE  | waiting for the first rise, counter cleared
//   HIGH  | input high, counting towards the fall
//   LOW   | input low, counting towards the next rise (end of period)
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  pwm_capture_if.slave bus
);

  localparam logic [CNT_W-1:0] C_MAX = CNT_W'(cnt_max(CNT_W));

  logic w_lvl, w_rise, w_fall;

  sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .rst    (rst),
    .i_d    (bus.pwm_i),
    .o_lvl  (w_lvl),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  pcap_state_e      r_state,  w_state_nxt;
  logic [CNT_W-1:0] r_cnt,    w_cnt_nxt;
  logic [CNT_W-1:0] r_high_q, w_high_q_nxt;
  logic [CNT_W-1:0] r_period, w_period_nxt;
  logic [CNT_W-1:0] r_high,   w_high_nxt;
  logic             r_valid,  w_valid_nxt;
  logic             r_timeout, w_timeout_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_sat;

  assign w_sat     = (r_cnt == C_MAX);
  assign w_cnt_inc = w_sat ? r_cnt : r_cnt + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_high_q  <= '0;
      r_period  <= '0;
      r_high    <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_high_q  <= w_high_q_nxt;
      r_period  <= w_period_nxt;
      r_high    <= w_high_nxt;
      r_valid   <= w_valid_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_high_q_nxt  = r_high_q;
    w_period_nxt  = r_period;
    w_high_nxt    = r_high;
    w_valid_nxt   = 1'b0;
    w_timeout_nxt = 1'b0;

    if (!bus.en_i) begin
      // Abort: results hold, no strobe; next result needs a full rise..rise.
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_rise) begin
            w_state_nxt = HIGH;
            w_cnt_nxt   = CNT_W'(1);
          end
        end
        HIGH: begin
          // Edge takes priority over a coincident saturation.
          if (w_fall) begin
            w_high_q_nxt = r_cnt;
            w_cnt_nxt    = w_cnt_inc;
            w_state_nxt  = LOW;
          end else if (w_sat) begin
            w_timeout_nxt = 1'b1;
            w_period_nxt  = '1;
            w_high_nxt    = '1;
            w_cnt_nxt     = '0;
            w_state_nxt   = IDLE;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        LOW: begin
          if (w_rise) begin
            // Close this period and start the next one with no dead cycle.
            w_period_nxt = r_cnt;
            w_high_nxt   = r_high_q;
            w_valid_nxt  = 1'b1;
            w_cnt_nxt    = CNT_W'(1);
            w_state_nxt  = HIGH;
          end else if (w_sat) begin
            w_timeout_nxt = 1'b1;
            w_period_nxt  = '1;
            w_high_nxt    = '0;
            w_cnt_nxt     = '0;
            w_state_nxt   = IDLE;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign bus.period_o  = r_period;
  assign bus.high_o    = r_high;
  assign bus.valid_o   = r_valid;
  assign bus.timeout_o = r_timeout;
  assign bus.level_o   = w_lvl;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture
//   Directed bench for pwm_capture: a 16-bit instance driven by a PWM
//   generator, and an 8-bit instance driven directly for timeout cases.
module tb_pwm_capture;

  logic clk;
  logic rst;

  pwm_capture_if #(.CNT_W(16)) bus16 ();
  pwm_capture_if #(.CNT_W(8))  bus8 ();

  pwm_capture #(.CNT_W(16), .SYNC_STAGES(2)) u_dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16)
  );

  pwm_capture #(.CNT_W(8), .SYNC_STAGES(2)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Returns 1 ns after a falling edge so monitor and generator have settled.
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // PWM generator for the 16-bit instance; H/P take effect at a period start.
  int gen_h = 30;
  int gen_p = 100;
  int cur_h = 30;
  int cur_p = 100;
  int phase = 0;
  bit gen_on = 1'b0;

  initial begin
    bus16.pwm_i = 1'b0;
    forever begin
      @(negedge clk);
      if (!gen_on) begin
        phase       = 0;
        bus16.pwm_i = 1'b0;
      end else begin
        if (phase == 0) begin
          cur_h = gen_h;
          cur_p = gen_p;
        end
        bus16.pwm_i = (phase < cur_h);
        phase       = (phase + 1 >= cur_p) ? 0 : phase + 1;
      end
    end
  end

  typedef struct {
    int p;
    int h;
  } res_t;

  res_t q[$];
  int   to16 = 0;
  int   to8  = 0;
  int   v8   = 0;
  int   both = 0;
  int   dbl  = 0;
  logic prev_v16 = 1'b0;

  always @(negedge clk) begin
    if (bus16.valid_o === 1'b1) q.push_back('{int'(bus16.period_o), int'(bus16.high_o)});
    if (bus16.timeout_o === 1'b1) to16++;
    if (bus8.timeout_o === 1'b1) to8++;
    if (bus8.valid_o === 1'b1) v8++;
    if ((bus16.valid_o & bus16.timeout_o) === 1'b1 || (bus8.valid_o & bus8.timeout_o) === 1'b1)
      both++;
    if (bus16.valid_o === 1'b1 && prev_v16 === 1'b1) dbl++;
    prev_v16 = bus16.valid_o;
  end

  task automatic chk_q(input string tag, input int n, input int p, input int h);
    chk({tag, "_count"}, q.size(), n);
    foreach (q[i]) begin
      chk($sformatf("%s_period[%0d]", tag, i), q[i].p, p);
      chk($sformatf("%s_high[%0d]", tag, i), q[i].h, h);
    end
  endtask

  initial begin
    int k;
    rst        = 1'b1;
    bus16.en_i = 1'b0;
    bus8.en_i  = 1'b0;
    bus8.pwm_i = 1'b0;
    wait_cyc(3);

    chk("rst_period", bus16.period_o, 0);
    chk("rst_high", bus16.high_o, 0);
    chk("rst_valid", bus16.valid_o, 0);
    chk("rst_timeout", bus16.timeout_o, 0);
    chk("rst_level", bus16.level_o, 0);
    chk("rst_period8", bus8.period_o, 0);

    // 1: H=30 P=100, five periods -> four results
    rst        = 1'b0;
    bus16.en_i = 1'b1;
    bus8.en_i  = 1'b1;
    gen_h      = 30;
    gen_p      = 100;
    gen_on     = 1'b1;
    wait_cyc(480);
    chk_q("t1", 4, 100, 30);
    chk("t1_timeout", to16, 0);

    // 2: duty change to 70 at a period boundary
    gen_h = 70;
    q.delete();
    wait_cyc(300);
    chk("t2_count", q.size(), 3);
    if (q.size() == 3) begin
      chk("t2_high0", q[0].h, 30);
      chk("t2_high1", q[1].h, 70);
      chk("t2_high2", q[2].h, 70);
      chk("t2_period2", q[2].p, 100);
    end

    // 3: narrow pulses H=1 P=3 -> a result every 3 cycles
    gen_h = 1;
    gen_p = 3;
    wait_cyc(100);
    q.delete();
    wait_cyc(30);
    chk_q("t3", 10, 3, 1);

    // 5: enable dropped mid-HIGH, then restored
    gen_h = 30;
    gen_p = 100;
    wait_cyc(250);
    k = 0;
    while (phase != 15 && k < 200) begin
      wait_cyc(1);
      k++;
    end
    chk("t5_sync_bound", (k < 200), 1);
    chk("t5_level_high", bus16.level_o, 1);
    bus16.en_i = 1'b0;
    q.delete();
    wait_cyc(20);
    chk("t5_hold_period", bus16.period_o, 100);
    chk("t5_hold_high", bus16.high_o, 30);
    chk("t5_off_count", q.size(), 0);
    bus16.en_i = 1'b1;
    wait_cyc(100);
    chk("t5_first_rise_count", q.size(), 0);
    wait_cyc(80);
    chk_q("t5", 1, 100, 30);

    // 6: async reset mid-LOW
    k = 0;
    while (phase != 60 && k < 200) begin
      wait_cyc(1);
      k++;
    end
    chk("t6_sync_bound", (k < 200), 1);
    rst = 1'b1;
    #1;
    chk("t6_rst_period", bus16.period_o, 0);
    chk("t6_rst_high", bus16.high_o, 0);
    chk("t6_rst_level", bus16.level_o, 0);
    wait_cyc(2);
    q.delete();
    rst = 1'b0;
    wait_cyc(250);
    chk_q("t6", 2, 100, 30);
    chk("t16_no_timeout", to16, 0);

    // 4: CNT_W=8 held high after a rise: 2 sync + 1 output cycles + 255
    to8        = 0;
    bus8.pwm_i = 1'b1;
    k          = 0;
    while (bus8.timeout_o !== 1'b1 && k < 400) begin
      wait_cyc(1);
      k++;
    end
    chk("t4_hi_latency", k, 258);
    chk("t4_hi_period", bus8.period_o, 8'hFF);
    chk("t4_hi_high", bus8.high_o, 8'hFF);
    wait_cyc(300);
    chk("t4_idle_no_retrigger", to8, 1);

    // Rise, 10 cycles high, then held low: timeout 255 cycles after the rise
    bus8.pwm_i = 1'b0;
    wait_cyc(5);
    bus8.pwm_i = 1'b1;
    wait_cyc(10);
    bus8.pwm_i = 1'b0;
    k          = 0;
    while (bus8.timeout_o !== 1'b1 && k < 400) begin
      wait_cyc(1);
      k++;
    end
    chk("t4_lo_latency", k, 248);
    chk("t4_lo_period", bus8.period_o, 8'hFF);
    chk("t4_lo_high", bus8.high_o, 8'h00);
    chk("t4_no_valid8", v8, 0);
    wait_cyc(2);
    chk("t4_timeout_count", to8, 2);

    chk("valid_timeout_overlap", both, 0);
    chk("valid_multi_cycle", dbl, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
